// File: rtl/rca4_seq_ctrl.sv
// Sequential WIDTH-bit adder that reuses one 4-bit ripple-carry adder, one nibble per clock, LSB first.
// Optional macro RCA4_SEQ_SUB_EN adds a 'sub' port that selects A-B (B inverted, initial carry forced to 1).

module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    always_comb begin
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[4];
    end
endmodule

module rca4_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef RCA4_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
    logic [KW-1:0]    k;
    logic             carry_q;
    logic [3:0]       nib_a, nib_b, nib_s;
    logic             nib_co;

    rca4 u_rca4 (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < N; i++) begin
            if (k == i[KW-1:0]) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    // Accumulator with the current nibble merged in; lets s load the complete sum on the last step.
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < N; i++) begin
            if (k == i[KW-1:0]) acc_next[4*i +: 4] = nib_s;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            s       <= '0;
            co      <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            carry_q <= 1'b0;
            k       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_q <= a;
`ifdef RCA4_SEQ_SUB_EN
                        // Subtraction stores ~B and seeds the chain with 1 (two's complement).
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | ci;
`else
                        b_q     <= b;
                        carry_q <= ci;
`endif
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc     <= acc_next;
                    carry_q <= nib_co;
                    if (k == K_LAST) begin
                        s     <= acc_next;
                        co    <= nib_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rca4_seq_ctrl.sv
// Directed bench for rca4_seq_ctrl: WIDTH=32 and WIDTH=4 instances, hand-computed expected sums.
// Subtraction vectors run only when RCA4_SEQ_SUB_EN is defined.

module tb_rca4_seq_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        ci = 1'b0;
    logic        busy, done, co;
    logic [31:0] s;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        ci4 = 1'b0;
    logic        busy4, done4, co4;
    logic [3:0]  s4;

`ifdef RCA4_SEQ_SUB_EN
    logic        sub = 1'b0;
    logic        sub4 = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca4_seq_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ci(ci),
`ifdef RCA4_SEQ_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .s(s), .co(co)
    );

    rca4_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .ci(ci4),
`ifdef RCA4_SEQ_SUB_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .s(s4), .co(co4)
    );

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic civ);
        a = av; b = bv; ci = civ; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after the accepting edge; returns edges until done, busy cycles seen, and whether s held.
    task automatic wait_done(output int cyc, output int bcnt, output bit hold_ok, output bit timed_out);
        logic [31:0] s_prev;
        s_prev    = s;
        cyc       = 0;
        bcnt      = busy ? 1 : 0;
        hold_ok   = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) bcnt++;
            if (s !== s_prev) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, co, s} !== 35'd0) begin
            errors++;
            $display("FAIL reset32 busy=%b done=%b co=%b s=%h expected all zero", busy, done, co, s);
        end
        checks++;
        if ({busy4, done4, co4, s4} !== 7'd0) begin
            errors++;
            $display("FAIL reset4 busy=%b done=%b co=%b s=%h expected all zero", busy4, done4, co4, s4);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_add();
        int cyc, bcnt; bit hold_ok, to;
        start_op(32'h0000_0001, 32'h0000_0002, 1'b0);
        wait_done(cyc, bcnt, hold_ok, to);
        checks++;
        if (to || cyc != 8) begin
            errors++;
            $display("FAIL basic_latency got %0d edges (timeout=%b) expected 8", cyc, to);
        end
        checks++;
        if (bcnt != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d expected 8", bcnt);
        end
        checks++;
        if (s !== 32'h0000_0003 || co !== 1'b0) begin
            errors++;
            $display("FAIL basic_result s=%h co=%b expected 00000003 0", s, co);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || s !== 32'h0000_0003) begin
            errors++;
            $display("FAIL basic_after done=%b busy=%b s=%h expected 0 0 00000003", done, busy, s);
        end
    endtask

    task automatic test_carry_ripple();
        int cyc, bcnt; bit hold_ok, to;
        start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_done(cyc, bcnt, hold_ok, to);
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL ripple_hold s changed before done, now %h expected hold of 00000003", s);
        end
        checks++;
        if (to || s !== 32'h0000_0000 || co !== 1'b1) begin
            errors++;
            $display("FAIL ripple_result s=%h co=%b timeout=%b expected 00000000 1", s, co, to);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s !== 32'h0 || co !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ripple_idle_hold s=%h co=%b done=%b expected 00000000 1 0", s, co, done);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bcnt; bit hold_ok, to;
        a = 32'h1234_5678; b = 32'h1111_1111; ci = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 32'h8000_0000; b = 32'h8000_0000;
        wait_done(cyc, bcnt, hold_ok, to);
        checks++;
        if (to || cyc != 8 || s !== 32'h2345_6789 || co !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first s=%h co=%b edges=%0d expected 23456789 0 8", s, co, cyc);
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept busy=%b done=%b expected 1 0", busy, done);
        end
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; ci = 1'b1;
        wait_done(cyc, bcnt, hold_ok, to);
        checks++;
        if (to || cyc != 8 || s !== 32'h0000_0000 || co !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second s=%h co=%b edges=%0d expected 00000000 1 8", s, co, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int cyc, bcnt; bit hold_ok, to;
        bit saw_done;
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || s !== 32'h0 || co !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset busy=%b s=%h co=%b done=%b expected 0 0 0 0", busy, s, co, done);
        end
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done saw_done=%b busy=%b expected 0 0", saw_done, busy);
        end
        a = 32'h1; b = 32'h1; reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins busy=%b expected 0", busy);
        end
        start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        wait_done(cyc, bcnt, hold_ok, to);
        checks++;
        if (to || cyc != 8 || s !== 32'hFFFF_FFFF || co !== 1'b0) begin
            errors++;
            $display("FAIL midrun_fresh s=%h co=%b edges=%0d expected ffffffff 0 8", s, co, cyc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width4();
        int cyc;
        bit to;
        bit busy_seen;
        a4 = 4'hF; b4 = 4'h1; ci4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        busy_seen = busy4;
        cyc = 0;
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done4) begin
                to = 1'b0;
                break;
            end
        end
        checks++;
        if (to || cyc != 1 || !busy_seen) begin
            errors++;
            $display("FAIL w4_latency edges=%0d busy_seen=%b timeout=%b expected 1 1 0", cyc, busy_seen, to);
        end
        checks++;
        if (s4 !== 4'h0 || co4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL w4_result s=%h co=%b busy=%b expected 0 1 0", s4, co4, busy4);
        end
        @(posedge clk); #1;
    endtask

`ifdef RCA4_SEQ_SUB_EN
    task automatic test_sub();
        int cyc, bcnt; bit hold_ok, to;
        sub = 1'b1;
        start_op(32'd5, 32'd7, 1'b0);
        sub = 1'b0;
        wait_done(cyc, bcnt, hold_ok, to);
        checks++;
        if (to || cyc != 8 || s !== 32'hFFFF_FFFE || co !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow s=%h co=%b edges=%0d expected fffffffe 0 8", s, co, cyc);
        end
        @(posedge clk); #1;
        sub = 1'b1;
        start_op(32'd7, 32'd5, 1'b0);
        sub = 1'b0;
        wait_done(cyc, bcnt, hold_ok, to);
        checks++;
        if (to || s !== 32'h0000_0002 || co !== 1'b1) begin
            errors++;
            $display("FAIL sub_noborrow s=%h co=%b expected 00000002 1", s, co);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_carry_ripple();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
`ifdef RCA4_SEQ_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
